// File: rtl/gpu_pkg.sv
// Shared GPU display-pipeline types and sizing helpers.
package gpu_pkg;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  function automatic int idx_bits(input int palette_length);
    return (palette_length > 1) ? $clog2(palette_length) : 1;
  endfunction

  function automatic int pix_per_word(input int data_bits, input int ib);
    return data_bits / ib;
  endfunction

  function automatic int words_per_line(input int src_w, input int ppw);
    return (src_w + ppw - 1) / ppw;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_line_buffer.sv
// One-write-port, one-read-port line store with registered read data (1-cycle read latency).
module fb_line_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/framebuffer_fetcher.sv
// Streams one frame of palette indices from framebuffer BRAM into the pixel FIFO, replicating DOWNSCALE_FACTOR x in both axes.
// First write 3 cycles after start_i; writes gated combinationally by prog_full/full. FB_FETCH_LINE_BUFFER_EN replays lines from a line buffer.
module framebuffer_fetcher
  import gpu_pkg::*;
#(
  parameter int H_VIS_AREA_PXL   = 800,
  parameter int V_VIS_AREA_PXL   = 600,
  parameter int DOWNSCALE_FACTOR = 2,
  parameter int PALETTE_LENGTH   = 256,
  parameter int BRAM_ADDR_BITS   = 32,
  parameter int BRAM_DATA_BITS   = 32,
  parameter logic [BRAM_ADDR_BITS-1:0] FB_BASE_ADDR = '0
) (
  input  logic                               gpu_clk_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  output logic                               busy_o,
  output logic                               frame_done_o,
  output logic                               bram_clk_o,
  output logic                               bram_rst_o,
  output logic                               bram_en_o,
  output logic [BRAM_ADDR_BITS-1:0]          bram_addr_o,
  input  logic [BRAM_DATA_BITS-1:0]          bram_dout_i,
  output logic [BRAM_DATA_BITS-1:0]          bram_din_o,
  output logic [BRAM_DATA_BITS/8-1:0]        bram_we_o,
  output logic                               pxl_fifo_wr_en_o,
  output logic [$clog2(PALETTE_LENGTH)-1:0]  pxl_fifo_write_data_o,
  input  logic                               pxl_fifo_prog_full_i,
  input  logic                               pxl_fifo_full_i
);

  localparam int IDX_BITS       = idx_bits(PALETTE_LENGTH);
  localparam int SRC_W          = H_VIS_AREA_PXL / DOWNSCALE_FACTOR;
  localparam int SRC_H          = V_VIS_AREA_PXL / DOWNSCALE_FACTOR;
  localparam int PPW            = pix_per_word(BRAM_DATA_BITS, IDX_BITS);
  localparam int WPL            = words_per_line(SRC_W, PPW);
  localparam int BYTES_PER_WORD = BRAM_DATA_BITS / 8;
  localparam int HW             = cnt_bits(SRC_W);
  localparam int YW             = cnt_bits(SRC_H);
  localparam int WW             = cnt_bits(WPL);
  localparam int PW             = cnt_bits(PPW);
  localparam int RW             = cnt_bits(DOWNSCALE_FACTOR);

  typedef logic [BRAM_DATA_BITS-1:0] word_t;

  fetch_state_e state_q, state_d;
  logic [WW-1:0] fetch_word_q, fetch_word_d;
  logic [RW-1:0] fetch_rep_q, fetch_rep_d;
  logic [YW-1:0] fetch_line_q, fetch_line_d;
  logic          fetch_done_q, fetch_done_d;
  logic          inflight_q, inflight_d;
  word_t         buf_q [2];
  word_t         buf_d [2];
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [HW-1:0] h_q, h_d;
  logic [RW-1:0] line_rep_q, line_rep_d;
  logic [YW-1:0] line_q, line_d;

  logic          run, can_issue, issue, push, pop, wr_en, last_wr;
  word_t         in_word, cur_word;
  logic [BRAM_ADDR_BITS-1:0] fetch_addr;

`ifdef FB_FETCH_LINE_BUFFER_EN
  logic          inflight_bram_q, inflight_bram_d;
  logic [WW-1:0] inflight_word_q, inflight_word_d;
  logic          from_bram;
  word_t         lb_rd_data;

  // First replay of each source line comes from BRAM and is recorded here.
  assign from_bram = (fetch_rep_q == '0);

  fb_line_buffer #(
    .DEPTH (WPL),
    .WIDTH (BRAM_DATA_BITS),
    .AW    (WW)
  ) u_line_buffer (
    .clk     (gpu_clk_i),
    .wr_en   (inflight_q && inflight_bram_q),
    .wr_addr (inflight_word_q),
    .wr_data (bram_dout_i),
    .rd_en   (issue && !from_bram),
    .rd_addr (fetch_word_q),
    .rd_data (lb_rd_data)
  );
`endif

  assign run      = (state_q == FETCH_RUN);
  assign cur_word = buf_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    fetch_word_d = fetch_word_q;
    fetch_rep_d  = fetch_rep_q;
    fetch_line_d = fetch_line_q;
    fetch_done_d = fetch_done_q;
    buf_d        = buf_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pix_d        = pix_q;
    rep_d        = rep_q;
    h_d          = h_q;
    line_rep_d   = line_rep_q;
    line_d       = line_q;
    issue        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    last_wr      = 1'b0;
    in_word      = bram_dout_i;
`ifdef FB_FETCH_LINE_BUFFER_EN
    if (!inflight_bram_q) in_word = lb_rd_data;
`endif

    can_issue = run && !fetch_done_q && ((count_q + {1'b0, inflight_q}) < 2'd2);
`ifdef FB_FETCH_LINE_BUFFER_EN
    // Avoid reading a line-buffer word in the same cycle it is still being recorded.
    if (!from_bram && inflight_bram_q) can_issue = 1'b0;
`endif
    if (can_issue) begin
      issue = 1'b1;
      if (fetch_word_q == WW'(WPL - 1)) begin
        fetch_word_d = '0;
        if (fetch_rep_q == RW'(DOWNSCALE_FACTOR - 1)) begin
          fetch_rep_d = '0;
          if (fetch_line_q == YW'(SRC_H - 1)) begin
            fetch_line_d = '0;
            fetch_done_d = 1'b1;
          end else begin
            fetch_line_d = fetch_line_q + 1'b1;
          end
        end else begin
          fetch_rep_d = fetch_rep_q + 1'b1;
        end
      end else begin
        fetch_word_d = fetch_word_q + 1'b1;
      end
    end

    // Returning read data is always captured; issue gating guarantees a free entry.
    if (run && inflight_q) begin
      push            = 1'b1;
      buf_d[wr_ptr_q] = in_word;
      wr_ptr_d        = ~wr_ptr_q;
    end

    wr_en = run && (count_q != 2'd0) && !pxl_fifo_prog_full_i && !pxl_fifo_full_i;
    if (wr_en) begin
      if (rep_q == RW'(DOWNSCALE_FACTOR - 1)) begin
        rep_d = '0;
        if (h_q == HW'(SRC_W - 1)) begin
          h_d      = '0;
          pix_d    = '0;
          pop      = 1'b1;
          if (line_rep_q == RW'(DOWNSCALE_FACTOR - 1)) begin
            line_rep_d = '0;
            if (line_q == YW'(SRC_H - 1)) begin
              line_d  = '0;
              last_wr = 1'b1;
              state_d = FETCH_IDLE;
            end else begin
              line_d = line_q + 1'b1;
            end
          end else begin
            line_rep_d = line_rep_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
          if (pix_q == PW'(PPW - 1)) begin
            pix_d = '0;
            pop   = 1'b1;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    // Start (or restart) wins over everything this cycle, including a final write.
    if (start_i) begin
      state_d      = FETCH_RUN;
      fetch_word_d = '0;
      fetch_rep_d  = '0;
      fetch_line_d = '0;
      fetch_done_d = 1'b0;
      count_d      = '0;
      wr_ptr_d     = 1'b0;
      rd_ptr_d     = 1'b0;
      pix_d        = '0;
      rep_d        = '0;
      h_d          = '0;
      line_rep_d   = '0;
      line_d       = '0;
      issue        = 1'b0;
      wr_en        = 1'b0;
      last_wr      = 1'b0;
    end

    inflight_d = issue;
`ifdef FB_FETCH_LINE_BUFFER_EN
    inflight_bram_d = issue && from_bram;
    inflight_word_d = fetch_word_q;
`endif
  end

  always_ff @(posedge gpu_clk_i) begin
    if (reset_i) begin
      state_q      <= FETCH_IDLE;
      fetch_word_q <= '0;
      fetch_rep_q  <= '0;
      fetch_line_q <= '0;
      fetch_done_q <= 1'b0;
      inflight_q   <= 1'b0;
      buf_q        <= '{default: '0};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= '0;
      pix_q        <= '0;
      rep_q        <= '0;
      h_q          <= '0;
      line_rep_q   <= '0;
      line_q       <= '0;
`ifdef FB_FETCH_LINE_BUFFER_EN
      inflight_bram_q <= 1'b0;
      inflight_word_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_word_q <= fetch_word_d;
      fetch_rep_q  <= fetch_rep_d;
      fetch_line_q <= fetch_line_d;
      fetch_done_q <= fetch_done_d;
      inflight_q   <= inflight_d;
      buf_q        <= buf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pix_q        <= pix_d;
      rep_q        <= rep_d;
      h_q          <= h_d;
      line_rep_q   <= line_rep_d;
      line_q       <= line_d;
`ifdef FB_FETCH_LINE_BUFFER_EN
      inflight_bram_q <= inflight_bram_d;
      inflight_word_q <= inflight_word_d;
`endif
    end
  end

  assign fetch_addr = FB_BASE_ADDR +
      BRAM_ADDR_BITS'((int'(fetch_line_q) * WPL + int'(fetch_word_q)) * BYTES_PER_WORD);

`ifdef FB_FETCH_LINE_BUFFER_EN
  assign bram_en_o = issue && from_bram;
`else
  assign bram_en_o = issue;
`endif
  assign bram_addr_o           = bram_en_o ? fetch_addr : '0;
  assign bram_clk_o            = gpu_clk_i;
  assign bram_rst_o            = reset_i;
  assign bram_din_o            = '0;
  assign bram_we_o             = '0;
  assign busy_o                = run;
  assign frame_done_o          = last_wr;
  assign pxl_fifo_wr_en_o      = wr_en;
  assign pxl_fifo_write_data_o = cur_word[int'(pix_q) * IDX_BITS +: IDX_BITS];

endmodule

// File: tb/tb_framebuffer_fetcher.sv
// Drives a 16x4 and a 12x4 fetcher side by side from one stimulus and checks both streams against an arithmetic frame model.
module tb_framebuffer_fetcher;

  logic clk = 1'b0;
  logic rst, start, prog_full, full;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_busy, a_done, a_bclk, a_brst, a_en, a_wr;
  logic [31:0] a_addr, a_dout, a_din;
  logic [3:0]  a_we;
  logic [7:0]  a_wdata;
  logic b_busy, b_done, b_bclk, b_brst, b_en, b_wr;
  logic [31:0] b_addr, b_dout, b_din;
  logic [3:0]  b_we;
  logic [7:0]  b_wdata;

  framebuffer_fetcher #(.H_VIS_AREA_PXL(16), .V_VIS_AREA_PXL(4), .DOWNSCALE_FACTOR(2),
                        .PALETTE_LENGTH(256), .BRAM_ADDR_BITS(32), .BRAM_DATA_BITS(32),
                        .FB_BASE_ADDR(32'd0)) dut_a (
    .gpu_clk_i(clk), .reset_i(rst), .start_i(start), .busy_o(a_busy), .frame_done_o(a_done),
    .bram_clk_o(a_bclk), .bram_rst_o(a_brst), .bram_en_o(a_en), .bram_addr_o(a_addr),
    .bram_dout_i(a_dout), .bram_din_o(a_din), .bram_we_o(a_we), .pxl_fifo_wr_en_o(a_wr),
    .pxl_fifo_write_data_o(a_wdata), .pxl_fifo_prog_full_i(prog_full), .pxl_fifo_full_i(full));

  framebuffer_fetcher #(.H_VIS_AREA_PXL(12), .V_VIS_AREA_PXL(4), .DOWNSCALE_FACTOR(2),
                        .PALETTE_LENGTH(256), .BRAM_ADDR_BITS(32), .BRAM_DATA_BITS(32),
                        .FB_BASE_ADDR(32'd0)) dut_b (
    .gpu_clk_i(clk), .reset_i(rst), .start_i(start), .busy_o(b_busy), .frame_done_o(b_done),
    .bram_clk_o(b_bclk), .bram_rst_o(b_brst), .bram_en_o(b_en), .bram_addr_o(b_addr),
    .bram_dout_i(b_dout), .bram_din_o(b_din), .bram_we_o(b_we), .pxl_fifo_wr_en_o(b_wr),
    .pxl_fifo_write_data_o(b_wdata), .pxl_fifo_prog_full_i(prog_full), .pxl_fifo_full_i(full));

  // BRAM contents: byte at address k holds k (mod 256), little-endian within a word.
  always @(posedge clk) begin
    if (a_en) a_dout <= {a_addr[7:0] + 8'd3, a_addr[7:0] + 8'd2, a_addr[7:0] + 8'd1, a_addr[7:0]};
    if (b_en) b_dout <= {b_addr[7:0] + 8'd3, b_addr[7:0] + 8'd2, b_addr[7:0] + 8'd1, b_addr[7:0]};
  end

  int a_q[$], b_q[$], a_wcyc[$];
  int a_en_first = -1, a_reads = 0, b_reads = 0, a_dones = 0, b_dones = 0, full_viol = 0;

  always @(negedge clk) begin
    if (a_wr) begin
      a_q.push_back(int'(a_wdata));
      a_wcyc.push_back(cyc);
      if (full) full_viol++;
    end
    if (b_wr) begin
      b_q.push_back(int'(b_wdata));
      if (full) full_viol++;
    end
    if (a_en) begin
      a_reads++;
      if (a_en_first < 0) a_en_first = cyc;
    end
    if (b_en) b_reads++;
    if (a_done) a_dones++;
    if (b_done) b_dones++;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Output pixel k of an h-wide, 4-line frame: source (ox/2, oy/2), lines padded to whole words.
  function automatic int exp_pix(input int h, input int k);
    int src_w, wpl, ox, oy;
    src_w = h / 2;
    wpl   = (src_w + 3) / 4;
    oy    = k / h;
    ox    = k % h;
    return ((oy / 2) * wpl * 4 + ox / 2) % 256;
  endfunction

  task automatic check_stream(input string tag, input int h, input int q[$]);
    int n;
    chk($sformatf("%s_len", tag), 64'(q.size()), 64'(h * 4));
    n = (q.size() < h * 4) ? q.size() : h * 4;
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_pix%0d", tag, i), 64'(q[i]), 64'(exp_pix(h, i)));
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    a_q.delete(); b_q.delete(); a_wcyc.delete();
    a_en_first = -1; a_reads = 0; b_reads = 0; a_dones = 0; b_dones = 0; full_viol = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((a_busy || b_busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(n < 3000), 64'd1);
  endtask

  int s, exp_reads, pad_hits;
  logic stop;

  initial begin
    rst = 1'b1; start = 1'b0; prog_full = 1'b0; full = 1'b0; stop = 1'b0;
`ifdef FB_FETCH_LINE_BUFFER_EN
    exp_reads = 4;
`else
    exp_reads = 8;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_a", 64'(a_busy), 64'd0);
    chk("rst_done_a", 64'(a_done), 64'd0);
    chk("rst_en_a", 64'(a_en), 64'd0);
    chk("rst_addr_a", 64'(a_addr), 64'd0);
    chk("rst_wr_a", 64'(a_wr), 64'd0);
    chk("rst_wdata_a", 64'(a_wdata), 64'd0);
    chk("rst_din_a", 64'(a_din), 64'd0);
    chk("rst_we_a", 64'(a_we), 64'd0);
    chk("rst_bram_rst_a", 64'(a_brst), 64'd1);
    chk("bram_clk_a", 64'(a_bclk), 64'(clk));
    chk("rst_busy_b", 64'(b_busy), 64'd0);
    chk("rst_en_b", 64'(b_en), 64'd0);
    chk("rst_wr_b", 64'(b_wr), 64'd0);
    chk("rst_misc_b", 64'({b_done, b_addr, b_din, b_we, b_brst, b_bclk}), 64'({1'b0, 32'd0, 32'd0, 4'd0, 1'b1, clk}));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy_a", 64'(a_busy), 64'd0);

    // Unstalled frame: latency, back-to-back writes, stream content, read count.
    pulse_start(s);
    chk("start_busy_a", 64'(a_busy), 64'd1);
    wait_idle("timeout_plain");
    repeat (3) @(posedge clk);
    check_stream("plain_a", 16, a_q);
    check_stream("plain_b", 12, b_q);
    chk("first_en_cyc", 64'(a_en_first), 64'(s + 1));
    if (a_wcyc.size() == 64) begin
      chk("first_wr_cyc", 64'(a_wcyc[0]), 64'(s + 3));
      chk("burst_span", 64'(a_wcyc[63] - a_wcyc[0]), 64'd63);
    end
    chk("reads_a", 64'(a_reads), 64'(exp_reads));
    chk("reads_b", 64'(b_reads), 64'(exp_reads));
    chk("dones_a", 64'(a_dones), 64'd1);
    chk("dones_b", 64'(b_dones), 64'd1);
    pad_hits = 0;
    foreach (b_q[i]) if ((b_q[i] % 8) >= 6) pad_hits++;
    chk("pad_bytes_b", 64'(pad_hits), 64'd0);

    // Pseudo-random prog_full/full: identical stream, nothing written while full.
    pulse_start(s);
    stop = 1'b0;
    fork
      begin
        wait_idle("timeout_stall");
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          prog_full = ($urandom_range(0, 3) == 0);
          full      = ($urandom_range(0, 7) == 0);
          @(posedge clk); #1;
        end
        prog_full = 1'b0;
        full      = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    check_stream("stall_a", 16, a_q);
    check_stream("stall_b", 12, b_q);
    chk("full_viol", 64'(full_viol), 64'd0);
    chk("stall_dones_a", 64'(a_dones), 64'd1);
    chk("stall_dones_b", 64'(b_dones), 64'd1);

    // Restart in the middle of output line 1.
    pulse_start(s);
    for (int n = 0; n < 200 && a_q.size() < 21; n++) begin
      @(posedge clk); #1;
    end
    chk("reached_line1", 64'(a_q.size() >= 21), 64'd1);
    pulse_start(s);
    wait_idle("timeout_restart");
    repeat (3) @(posedge clk);
    check_stream("restart_a", 16, a_q);
    check_stream("restart_b", 12, b_q);
    chk("restart_dones_a", 64'(a_dones), 64'd1);
    chk("restart_first_en", 64'(a_en_first), 64'(s + 1));

    // Reset and start together mid-frame: reset wins.
    pulse_start(s);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy_a", 64'(a_busy), 64'd0);
    chk("rst_start_busy_b", 64'(b_busy), 64'd0);
    chk("rst_start_en_a", 64'(a_en), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_start_stays_idle", 64'({a_busy, a_wr, b_busy, b_wr}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
